// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller state encodings, opcode constants,
// instruction field positions and the no-register select code.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    DISPATCH  = 3'd3,
    WAIT_EXEC = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [3:0] ADD_OP  = 4'h1;
  localparam logic [3:0] HALT_OP = 4'hF;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int P1_MSB = 11;
  localparam int P1_LSB = 6;
  localparam int P2_MSB = 5;
  localparam int P2_LSB = 0;

  localparam logic [5:0] NO_REG = 6'b111111;

endpackage

// File: rtl/fetch_decode_fsm_instr_decoder.sv
// Purely combinational instruction splitter: IR -> opCode/para1/para2 plus
// legality and halt flags.
module instr_decoder #(
  parameter int         INSTR_W    = 16,
  parameter logic [15:0] LEGAL_MASK = 16'h7FFF,
  parameter logic [3:0]  HALT_OP    = cpu_pkg::HALT_OP
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         opCode,
  output logic [5:0]         para1,
  output logic [5:0]         para2,
  output logic               legal,
  output logic               isHalt
);
  import cpu_pkg::*;

  assign opCode = ir[OP_MSB:OP_LSB];
  assign para1  = ir[P1_MSB:P1_LSB];
  assign para2  = ir[P2_MSB:P2_LSB];
  assign legal  = LEGAL_MASK[opCode];
  assign isHalt = (opCode == HALT_OP);

endmodule

// File: rtl/fetch_decode_fsm.sv
// Instruction fetch/decode controller: owns the PC, fetches one word, decodes it
// and dispatches to the execute stage. Optional memory-wait timeout: FETCH_TIMEOUT_EN.
module fetch_decode_fsm #(
  parameter int          ADDR_W      = 6,
  parameter int          INSTR_W     = 16,
  parameter logic [15:0] LEGAL_MASK  = 16'h7FFF,
  parameter logic [3:0]  HALT_OP     = cpu_pkg::HALT_OP,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  memAddr,
  output logic               memRead,
  input  logic [INSTR_W-1:0] memData,
  input  logic               memValid,
  output logic [3:0]         opCode,
  output logic [5:0]         para1,
  output logic [5:0]         para2,
  output logic               start,
  input  logic               incr,
  input  logic               fetch,
  output logic               halted,
  output logic               err
);
  import cpu_pkg::*;

  state_t              state, stateNxt;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic                errSet;
  logic                showFields;
  logic                pcAdv;
  logic                fetchTimeout;
  logic [3:0]          decOp;
  logic [5:0]          decP1, decP2;
  logic                decLegal, decHalt;

  instr_decoder #(
    .INSTR_W   (INSTR_W),
    .LEGAL_MASK(LEGAL_MASK),
    .HALT_OP   (HALT_OP)
  ) uDecoder (
    .ir    (ir),
    .opCode(decOp),
    .para1 (decP1),
    .para2 (decP2),
    .legal (decLegal),
    .isHalt(decHalt)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] waitCnt;

  // Counts cycles spent in FETCH; any other state re-arms it to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= (state == FETCH) ? waitCnt + TO_W'(1) : '0;
    end
  end

  assign fetchTimeout = (waitCnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Timeout disabled: folds to a constant 0 for any legal TIMEOUT_CYC.
  assign fetchTimeout = (TIMEOUT_CYC < 0);
`endif

  assign pcAdv = incr && (state inside {FETCH, DECODE, DISPATCH, WAIT_EXEC});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      err   <= 1'b0;
    end else begin
      state <= stateNxt;
      if (state == FETCH && memValid) ir <= memData;
      if (pcAdv) pc <= pc + ADDR_W'(1);
      if (errSet) err <= 1'b1;
    end
  end

  always_comb begin
    stateNxt   = state;
    errSet     = 1'b0;
    memRead    = 1'b0;
    start      = 1'b0;
    halted     = 1'b0;
    showFields = 1'b0;
    case (state)
      IDLE: begin
        if (run) stateNxt = FETCH;
      end
      FETCH: begin
        memRead = 1'b1;
        if (memValid) begin
          stateNxt = DECODE;
        end else if (fetchTimeout) begin
          errSet   = 1'b1;
          stateNxt = HALT;
        end
      end
      DECODE: begin
        showFields = 1'b1;
        if (decHalt) begin
          stateNxt = HALT;
        end else if (!decLegal) begin
          errSet   = 1'b1;
          stateNxt = HALT;
        end else begin
          stateNxt = DISPATCH;
        end
      end
      DISPATCH: begin
        showFields = 1'b1;
        start      = 1'b1;
        stateNxt   = WAIT_EXEC;
      end
      WAIT_EXEC: begin
        showFields = 1'b1;
        if (fetch) stateNxt = run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign memAddr = pc;
  assign opCode  = showFields ? decOp : 4'b0;
  assign para1   = showFields ? decP1 : NO_REG;
  assign para2   = showFields ? decP2 : NO_REG;

endmodule

// File: tb/tb_fetch_decode_fsm.sv
// Directed bench for fetch_decode_fsm; opcode 7 is made illegal via LEGAL_MASK.
module tb_fetch_decode_fsm;

  logic        clk = 1'b0;
  logic        reset, run, memRead, memValid, start, incr, fetch, halted, err;
  logic [5:0]  memAddr, para1, para2;
  logic [15:0] memData;
  logic [3:0]  opCode;
  int          nCmp = 0;
  int          nFail = 0;

  always #5 clk = ~clk;

  fetch_decode_fsm #(
    .ADDR_W     (6),
    .INSTR_W    (16),
    .LEGAL_MASK (16'h7F7F),
    .HALT_OP    (4'hF),
    .TIMEOUT_CYC(15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .memAddr (memAddr),
    .memRead (memRead),
    .memData (memData),
    .memValid(memValid),
    .opCode  (opCode),
    .para1   (para1),
    .para2   (para2),
    .start   (start),
    .incr    (incr),
    .fetch   (fetch),
    .halted  (halted),
    .err     (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkFields(input string tag, input logic [3:0] op,
                           input logic [5:0] p1, input logic [5:0] p2);
    chk({tag, ".opCode"}, 16'(opCode), 16'(op));
    chk({tag, ".para1"},  16'(para1),  16'(p1));
    chk({tag, ".para2"},  16'(para2),  16'(p2));
  endtask

  task automatic chkIdleReset(input string tag);
    chk({tag, ".memRead"}, 16'(memRead), 16'h0);
    chk({tag, ".memAddr"}, 16'(memAddr), 16'h0);
    chk({tag, ".start"},   16'(start),   16'h0);
    chk({tag, ".halted"},  16'(halted),  16'h0);
    chk({tag, ".err"},     16'(err),     16'h0);
    chkFields(tag, 4'h0, 6'h3F, 6'h3F);
  endtask

  // Present one word for one cycle; leaves the DUT in DECODE.
  task automatic memReturn(input logic [15:0] word);
    memData  = word;
    memValid = 1'b1;
    tick();
    memValid = 1'b0;
    memData  = 16'h0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; memValid = 1'b0; memData = 16'h0;
    incr = 1'b0; fetch = 1'b0;
    tick();
    chkIdleReset("reset");

    reset = 1'b0; run = 1'b1;
    tick();
    chk("fetch0.memRead", 16'(memRead), 16'h1);
    chk("fetch0.memAddr", 16'(memAddr), 16'h0);
    tick();
    tick();
    chk("fetch0.wait2.memRead", 16'(memRead), 16'h1);
    chkFields("fetch0.fields", 4'h0, 6'h3F, 6'h3F);

    memReturn(16'h1083);
    chk("decode.start", 16'(start), 16'h0);
    chk("decode.memRead", 16'(memRead), 16'h0);
    chkFields("decode", 4'h1, 6'h02, 6'h03);
    tick();
    chk("dispatch.start", 16'(start), 16'h1);
    chkFields("dispatch", 4'h1, 6'h02, 6'h03);
    tick();
    chk("wait.start", 16'(start), 16'h0);

    incr = 1'b1;
    tick();
    incr = 1'b0;
    chkFields("wait.afterIncr", 4'h1, 6'h02, 6'h03);
    chk("wait.noRefetch", 16'(memRead), 16'h0);
    tick();
    tick();
    chkFields("wait.hold", 4'h1, 6'h02, 6'h03);
    chk("wait.start2", 16'(start), 16'h0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("fetch1.memRead", 16'(memRead), 16'h1);
    chk("fetch1.memAddr", 16'(memAddr), 16'h1);
    chkFields("fetch1.fields", 4'h0, 6'h3F, 6'h3F);

    memReturn(16'h1083);
    tick();
    chk("dispatch2.start", 16'(start), 16'h1);
    tick();
    incr = 1'b1; fetch = 1'b1;
    tick();
    incr = 1'b0; fetch = 1'b0;
    chk("sameCycle.memRead", 16'(memRead), 16'h1);
    chk("sameCycle.memAddr", 16'(memAddr), 16'h2);

    for (int i = 0; i < 61; i++) begin
      incr = 1'b1;
      tick();
    end
    incr = 1'b0;
    chk("wrap.preload", 16'(memAddr), 16'd63);
    memReturn(16'h1083);
    tick();
    tick();
    incr = 1'b1; fetch = 1'b1;
    tick();
    incr = 1'b0; fetch = 1'b0;
    chk("wrap.memRead", 16'(memRead), 16'h1);
    chk("wrap.memAddr", 16'(memAddr), 16'h0);

    memReturn(16'hF000);
    chk("haltDecode.start", 16'(start), 16'h0);
    tick();
    chk("halt.halted", 16'(halted), 16'h1);
    chk("halt.err", 16'(err), 16'h0);
    chk("halt.start", 16'(start), 16'h0);
    chk("halt.memRead", 16'(memRead), 16'h0);
    fetch = 1'b1; run = 1'b1;
    tick();
    fetch = 1'b0;
    chk("halt.sticky", 16'(halted), 16'h1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    memReturn(16'h7000);
    tick();
    chk("illegal.halted", 16'(halted), 16'h1);
    chk("illegal.err", 16'(err), 16'h1);
    chk("illegal.start", 16'(start), 16'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstAfterErr.err", 16'(err), 16'h0);
    tick();
    incr = 1'b1;
    tick();
    tick();
    tick();
    incr = 1'b0;
    chk("rstFetch.pre", 16'(memAddr), 16'h3);
    reset = 1'b1;
    tick();
    chkIdleReset("rstFetch");
    reset = 1'b0;
    tick();
    chk("rstFetch.resume.memRead", 16'(memRead), 16'h1);
    chk("rstFetch.resume.memAddr", 16'(memAddr), 16'h0);

    memReturn(16'h1083);
    tick();
    tick();
    incr = 1'b1;
    tick();
    incr = 1'b0;
    reset = 1'b1;
    tick();
    chkIdleReset("rstWait");
    reset = 1'b0;
    tick();
    chk("rstWait.resume.memRead", 16'(memRead), 16'h1);
    chk("rstWait.resume.memAddr", 16'(memAddr), 16'h0);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    chk("timeout.cycle15.memRead", 16'(memRead), 16'h1);
    chk("timeout.cycle15.halted", 16'(halted), 16'h0);
    tick();
    chk("timeout.halted", 16'(halted), 16'h1);
    chk("timeout.err", 16'(err), 16'h1);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("noTimeout.memRead", 16'(memRead), 16'h1);
    chk("noTimeout.halted", 16'(halted), 16'h0);
    chk("noTimeout.err", 16'(err), 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
